// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch-side next-PC select, wrong-path squash, halt, debug count.
// Optional return-address stack is built when RAS_EN is defined.
module pc_sequencer #(
  parameter int W = 16,
  parameter logic [W-1:0] RESET_VEC = '0,
  parameter int FLUSH_CYCLES = 2,
  parameter int RAS_DEPTH = 4
) (
  input  logic         clock,
  input  logic         resetn,
  input  logic         stall,
  input  logic         branch,
  input  logic         condpass,
  input  logic [W-1:0] target,
  input  logic         call,
  input  logic         ret,
  input  logic         halt,
  output logic [W-1:0] pc,
  output logic         valid,
  output logic         flush,
  output logic         halted,
  output logic [15:0]  takencnt,
  output logic         stackerr
);

  typedef enum logic [1:0] {
    S_RUN,
    S_FLUSH,
    S_HALT
  } state_t;

  localparam logic [W-1:0] ONE = W'(1);
  localparam logic [2:0] FC = 3'(FLUSH_CYCLES);

  state_t       state;
  logic [2:0]   fcnt;
  logic [W-1:0] seq;
  logic         take_br;

  assign seq     = pc + ONE;
  assign take_br = branch & condpass;

`ifdef RAS_EN
  localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam logic [PW-1:0] P1 = PW'(1);
  localparam logic [PW:0] C1 = (PW + 1)'(1);
  localparam logic [PW:0] DEPTH = (PW + 1)'(RAS_DEPTH);

  logic [W-1:0] ras [RAS_DEPTH];
  logic [PW-1:0] rptr;
  logic [PW:0]   rcnt;
  logic          take_ret;

  assign take_ret = ret & condpass;
`else
  logic unused;
  assign unused   = ^{call, ret};
  assign stackerr = 1'b0;
`endif

  // Next-PC selection, flush window sequencing and halt handling.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state    <= S_RUN;
      pc       <= RESET_VEC;
      valid    <= 1'b1;
      flush    <= 1'b0;
      halted   <= 1'b0;
      takencnt <= '0;
      fcnt     <= '0;
`ifdef RAS_EN
      stackerr <= 1'b0;
      rptr     <= '0;
      rcnt     <= '0;
      for (int i = 0; i < RAS_DEPTH; i++)
        ras[i] <= '0;
`endif
    end else begin
      // Squash pulse lasts one cycle even across a stall.
      flush <= 1'b0;
      if (!stall) begin
        unique case (state)
          S_RUN: begin
            if (halt) begin
              state  <= S_HALT;
              halted <= 1'b1;
            end
`ifdef RAS_EN
            else if (take_ret) begin
              if (rcnt == '0) begin
                pc       <= RESET_VEC;
                stackerr <= 1'b1;
              end else begin
                pc   <= ras[rptr - P1];
                rptr <= rptr - P1;
                rcnt <= rcnt - C1;
              end
              state <= S_FLUSH;
              fcnt  <= FC;
              valid <= 1'b0;
              flush <= 1'b1;
              if (takencnt != 16'hFFFF)
                takencnt <= takencnt + 16'd1;
            end
`endif
            else if (take_br) begin
              pc    <= target;
              state <= S_FLUSH;
              fcnt  <= FC;
              valid <= 1'b0;
              flush <= 1'b1;
              if (takencnt != 16'hFFFF)
                takencnt <= takencnt + 16'd1;
`ifdef RAS_EN
              // Full stack overwrites its oldest slot.
              if (call) begin
                ras[rptr] <= seq;
                rptr      <= rptr + P1;
                if (rcnt != DEPTH)
                  rcnt <= rcnt + C1;
              end
`endif
            end else begin
              pc <= seq;
            end
          end
          S_FLUSH: begin
            pc   <= seq;
            fcnt <= fcnt - 3'd1;
            if (fcnt == 3'd1) begin
              state <= S_RUN;
              valid <= 1'b1;
            end
          end
          S_HALT: begin
            halted <= 1'b1;
          end
          default: begin
            state <= S_RUN;
            valid <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed scoreboard bench for pc_sequencer.
// Expected fetch state is queued per cycle and checked after the edge.
module tb_pc_sequencer;

  logic        clock;
  logic        resetn;
  logic        stall;
  logic        branch;
  logic        condpass;
  logic [15:0] target;
  logic        call;
  logic        ret;
  logic        halt;
  logic [15:0] pc;
  logic        valid;
  logic        flush;
  logic        halted;
  logic [15:0] takencnt;
  logic        stackerr;

  int total = 0;
  int bad = 0;

  typedef struct {
    string       tag;
    logic [15:0] pc;
    logic        valid;
    logic        flush;
    logic        halted;
    logic [15:0] cnt;
    logic        err;
  } exp_t;

  exp_t sb[$];

  pc_sequencer #(
    .W(16),
    .RESET_VEC(16'h0000),
    .FLUSH_CYCLES(2),
    .RAS_DEPTH(4)
  ) dut (
    .clock(clock),
    .resetn(resetn),
    .stall(stall),
    .branch(branch),
    .condpass(condpass),
    .target(target),
    .call(call),
    .ret(ret),
    .halt(halt),
    .pc(pc),
    .valid(valid),
    .flush(flush),
    .halted(halted),
    .takencnt(takencnt),
    .stackerr(stackerr)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic cmp(string tag, string fld,
                     logic [15:0] got, logic [15:0] want);
    total++;
    assert (got === want)
    else begin
      bad++;
      $error("FAIL %s.%s got=%h want=%h", tag, fld, got, want);
    end
  endtask

  task automatic chk(exp_t e);
    cmp(e.tag, "pc", pc, e.pc);
    cmp(e.tag, "valid", 16'(valid), 16'(e.valid));
    cmp(e.tag, "flush", 16'(flush), 16'(e.flush));
    cmp(e.tag, "halted", 16'(halted), 16'(e.halted));
    cmp(e.tag, "takencnt", takencnt, e.cnt);
    cmp(e.tag, "stackerr", 16'(stackerr), 16'(e.err));
  endtask

  task automatic now(string tag, logic [15:0] p, logic v, logic f,
                     logic h, logic [15:0] c, logic e);
    exp_t x;
    x = '{tag, p, v, f, h, c, e};
    chk(x);
  endtask

  task automatic cyc(string tag, logic [15:0] p, logic v, logic f,
                     logic h, logic [15:0] c, logic e);
    exp_t x;
    sb.push_back('{tag, p, v, f, h, c, e});
    @(posedge clock);
    #1;
    x = sb.pop_front();
    chk(x);
  endtask

  task automatic idle();
    stall = 0; branch = 0; condpass = 0; target = '0;
    call = 0; ret = 0; halt = 0;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    #1;
    now("rst", 16'h0, 1, 0, 0, 16'd0, 0);
    @(posedge clock);
    #1;
    resetn = 1'b1;
  endtask

  initial begin
    idle();
    resetn = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    now("por", 16'h0, 1, 0, 0, 16'd0, 0);
    resetn = 1'b1;

    cyc("seq1", 16'h1, 1, 0, 0, 16'd0, 0);
    cyc("seq2", 16'h2, 1, 0, 0, 16'd0, 0);
    cyc("seq3", 16'h3, 1, 0, 0, 16'd0, 0);

    branch = 1; condpass = 1; target = 16'h40;
    cyc("br", 16'h40, 0, 1, 0, 16'd1, 0);
    idle();
    cyc("bub1", 16'h41, 0, 0, 0, 16'd1, 0);
    cyc("land", 16'h42, 1, 0, 0, 16'd1, 0);

    branch = 1; condpass = 0; target = 16'h40;
    cyc("nt", 16'h43, 1, 0, 0, 16'd1, 0);

    branch = 1; condpass = 1; target = 16'h43;
    cyc("self", 16'h43, 0, 1, 0, 16'd2, 0);
    idle();
    stall = 1;
    cyc("stl1", 16'h43, 0, 0, 0, 16'd2, 0);
    cyc("stl2", 16'h43, 0, 0, 0, 16'd2, 0);
    cyc("stl3", 16'h43, 0, 0, 0, 16'd2, 0);
    stall = 0;
    cyc("fl1", 16'h44, 0, 0, 0, 16'd2, 0);
    cyc("fl2", 16'h45, 1, 0, 0, 16'd2, 0);

    stall = 1; branch = 1; condpass = 1; target = 16'h99;
    cyc("runstl", 16'h45, 1, 0, 0, 16'd2, 0);
    idle();

    branch = 1; condpass = 1; target = 16'hFFFD;
    cyc("hi", 16'hFFFD, 0, 1, 0, 16'd3, 0);
    idle();
    cyc("hi1", 16'hFFFE, 0, 0, 0, 16'd3, 0);
    cyc("hi2", 16'hFFFF, 1, 0, 0, 16'd3, 0);
    cyc("wrap", 16'h0000, 1, 0, 0, 16'd3, 0);

    branch = 1; condpass = 1; target = 16'h20;
    cyc("b20", 16'h20, 0, 1, 0, 16'd4, 0);
    idle();
    halt = 1;
    cyc("hfl1", 16'h21, 0, 0, 0, 16'd4, 0);
    cyc("hfl2", 16'h22, 1, 0, 0, 16'd4, 0);
    cyc("halt", 16'h22, 1, 0, 1, 16'd4, 0);
    halt = 0; branch = 1; condpass = 1; target = 16'h77;
    for (int i = 0; i < 10; i++)
      cyc("hold", 16'h22, 1, 0, 1, 16'd4, 0);
    idle();
    do_reset();
    cyc("post", 16'h1, 1, 0, 0, 16'd0, 0);

    branch = 1; condpass = 1; target = 16'h50;
    cyc("b50", 16'h50, 0, 1, 0, 16'd1, 0);
    idle();
    do_reset();
    cyc("postfl", 16'h1, 1, 0, 0, 16'd0, 0);

`ifdef RAS_EN
    do_reset();
    branch = 1; condpass = 1; target = 16'h0E;
    cyc("b0e", 16'h0E, 0, 1, 0, 16'd1, 0);
    idle();
    cyc("b0e1", 16'h0F, 0, 0, 0, 16'd1, 0);
    cyc("at10", 16'h10, 1, 0, 0, 16'd1, 0);
    branch = 1; condpass = 1; call = 1; target = 16'h80;
    cyc("call", 16'h80, 0, 1, 0, 16'd2, 0);
    idle();
    cyc("call1", 16'h81, 0, 0, 0, 16'd2, 0);
    cyc("call2", 16'h82, 1, 0, 0, 16'd2, 0);
    ret = 1; condpass = 1; branch = 1; target = 16'h99;
    cyc("ret", 16'h11, 0, 1, 0, 16'd3, 0);
    idle();
    cyc("ret1", 16'h12, 0, 0, 0, 16'd3, 0);
    cyc("ret2", 16'h13, 1, 0, 0, 16'd3, 0);
    ret = 1; condpass = 1;
    cyc("under", 16'h0, 0, 1, 0, 16'd4, 1);
    idle();
    cyc("und1", 16'h1, 0, 0, 0, 16'd4, 1);
    cyc("und2", 16'h2, 1, 0, 0, 16'd4, 1);

    do_reset();
    cyc("c0", 16'h1, 1, 0, 0, 16'd0, 0);
    for (int k = 1; k <= 5; k++) begin
      branch = 1; condpass = 1; call = 1;
      target = 16'(k - 1);
      cyc("callk", 16'(k - 1), 0, 1, 0, 16'(k), 0);
      idle();
      cyc("callk1", 16'(k), 0, 0, 0, 16'(k), 0);
      cyc("callk2", 16'(k + 1), 1, 0, 0, 16'(k), 0);
    end
    for (int j = 0; j < 4; j++) begin
      ret = 1; condpass = 1;
      cyc("pop", 16'(6 - j), 0, 1, 0, 16'(6 + j), 0);
      idle();
      cyc("pop1", 16'(7 - j), 0, 0, 0, 16'(6 + j), 0);
      cyc("pop2", 16'(8 - j), 1, 0, 0, 16'(6 + j), 0);
    end
`else
    ret = 1; condpass = 1; call = 1;
    cyc("noret", 16'h2, 1, 0, 0, 16'd0, 0);
    branch = 1; target = 16'h70; ret = 0;
    cyc("nocall", 16'h70, 0, 1, 0, 16'd1, 0);
    idle();
    cyc("nc1", 16'h71, 0, 0, 0, 16'd1, 0);
    cyc("nc2", 16'h72, 1, 0, 0, 16'd1, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Fetch-side program counter sequencer. It sits directly downstream of the branch condition checker and consumes its single-bit pass result.
- Each cycle it chooses sequential, branch-target or (optionally) return-stack next PC.
- After a taken branch it squashes wrong-path instructions with a flush pulse and a bubble window.
- It also provides halt handling and a taken-branch counter for debug.

Parameters:
- W, 16, PC / address width in bits
- RESET_VEC, 0, PC value loaded on reset
- FLUSH_CYCLES, 2, number of invalid (bubble) cycles after a taken branch; legal range 1..7
- RAS_DEPTH, 4, return-stack entries; power of two; used only with RAS_EN

Ports:
- Clock  in  1  system clock; all state updates on rising edge
- Resetn  in  1  asynchronous active-low reset
- Stall  in  1  hold all state this cycle (PC, counters, FSM)
- Branch  in  1  current instruction is a conditional branch
- CondPass  in  1  condition-checker result; 1 = condition true
- Target  in  W  branch target address
- Call  in  1  branch also pushes return address (RAS_EN only)
- Ret  in  1  return: pop return stack into PC (RAS_EN only)
- Halt  in  1  halt request
- PC  out  W  current fetch address
- Valid  out  1  current fetch slot is on the correct path
- Flush  out  1  one-cycle squash pulse to downstream stages
- Halted  out  1  FSM is in HALT
- TakenCnt  out  16  saturating count of taken branches
- StackErr  out  1  sticky return-stack underflow flag

Behaviour:
- Reset, asynchronous on Resetn=0:
  - PC=RESET_VEC, state=RUN, Valid=1, Flush=0, Halted=0, TakenCnt=0, StackErr=0.
  - Flush counter=0, RAS pointer=0, RAS entries=0.
  - Reset mid-flush or mid-halt aborts immediately to these values.
- Stall=1 (any state): no register changes, except that Flush still deasserts (Flush is never stretched).
- Flush is registered and high only on the cycle after a taken branch/return is accepted.
- FSM states: RUN, FLUSH, HALT.
- RUN with Stall=0, priority high to low:
  - Halt=1 -> HALT, PC holds.
  - Ret=1 and CondPass=1 (RAS_EN) -> PC=popped entry, enter FLUSH.
  - Branch=1 and CondPass=1 -> PC=Target, TakenCnt+1 (saturates at 16'hFFFF), enter FLUSH.
  - Otherwise -> PC=PC+1 modulo 2^W (wraps 2^W-1 to 0).
  - Branch=1 with CondPass=0 is treated as sequential.
- Entering FLUSH: Flush=1 next cycle, flush counter=FLUSH_CYCLES, Valid=0.
- FLUSH with Stall=0:
  - PC=PC+1 and counter decrements.
  - Branch, Ret, Call and Halt are ignored (wrong path).
  - When the counter goes 1->0: state=RUN, Valid=1 on that same edge.
- HALT: PC, Valid and TakenCnt hold; Halted=1. Exit only via reset.
- Valid=1 exactly when state is RUN or HALT.
- Target==PC (branch to self) is legal and still flushes.
- TakenCnt also counts taken returns when RAS_EN is defined.

Optional Feature:
- Macro: RAS_EN.
- Defined:
  - RAS_DEPTH-entry return-address stack.
  - Taken branch with Call=1 pushes PC+1 (mod 2^W).
  - Push when full overwrites the oldest entry (circular pointer, count saturates at RAS_DEPTH).
  - Taken Ret pops; Ret takes priority over Branch in the same cycle.
  - Ret with an empty stack: PC=RESET_VEC, StackErr=1 sticky until reset, still enters FLUSH.
- Not defined:
  - Call is ignored (plain branch) and Ret is ignored (sequential).
  - StackErr is tied 0.
  - Ports remain present.

Test Plan:
- Reset with RESET_VEC=0, then 5 free cycles -> PC 0,1,2,3,4,5; Valid=1 throughout; Flush=0.
- At PC=3: Branch=1, CondPass=1, Target=0x40 ->
  - next PC=0x40, Flush=1 one cycle, Valid=0 for 2 cycles (PC 0x40, 0x41), Valid=1 at PC=0x42, TakenCnt=1.
  - Branch=1 with CondPass=0 -> PC=4, TakenCnt unchanged.
- Stall=1 for 3 cycles during FLUSH -> PC and flush counter frozen, Flush low after 1 cycle, bubble window extended by exactly 3 cycles.
- PC=0xFFFF, no branch -> PC=0x0000. Halt=1 -> Halted=1, PC frozen for 10 cycles. Resetn low mid-halt -> PC=0, Halted=0.
- With RAS_EN:
  - At PC=0x10: Call+Branch, Target=0x80 -> push 0x11.
  - Later Ret+CondPass -> PC=0x11, Flush=1.
  - Further Ret -> PC=RESET_VEC, StackErr=1.
- With RAS_EN: 5 calls from PCs 1..5 -> stack holds 3,4,5,6. Four returns -> PC 6,5,4,3, StackErr=0.
